// File: rtl/contador_param.sv
// WIDTH-bit up/down/step/load counter with registered Q, RCO and valid (1-cycle latency; cascade via cin).
// Define CONTADOR_SAT_EN to clamp at the limits instead of wrapping.
module contador_param #(
    parameter int WIDTH = 16,
    parameter int STEP  = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enb,
    input  logic             cin,
    input  logic [1:0]       modo,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic             RCO,
    output logic             valid
);

    localparam logic [WIDTH:0] ONE_X  = (WIDTH+1)'(1);
    localparam logic [WIDTH:0] STEP_X = (WIDTH+1)'(STEP);

    logic [WIDTH-1:0] r_q;
    logic             r_rco;
    logic             r_valid;

    logic             w_adv;
    logic [WIDTH:0]   w_ext;
    logic [WIDTH-1:0] w_q_nxt;
    logic             w_rco_nxt;

    assign w_adv = enb & cin;

    // One extra MSB carries the carry/borrow that becomes RCO.
    always_comb begin
        w_ext     = {1'b0, r_q};
        w_q_nxt   = r_q;
        w_rco_nxt = 1'b0;
        case (modo)
            2'b00:   w_ext = {1'b0, r_q} + ONE_X;
            2'b01:   w_ext = {1'b0, r_q} - ONE_X;
            2'b10:   w_ext = {1'b0, r_q} - STEP_X;
            default: w_ext = {1'b0, D};
        endcase
        w_q_nxt = w_ext[WIDTH-1:0];
        if (modo != 2'b11) begin
            w_rco_nxt = w_ext[WIDTH];
        end
`ifdef CONTADOR_SAT_EN
        if (w_rco_nxt) begin
            w_q_nxt = (modo == 2'b00) ? '1 : '0;
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_q     <= '0;
            r_rco   <= 1'b0;
            r_valid <= 1'b0;
        end else if (w_adv) begin
            r_q     <= w_q_nxt;
            r_rco   <= w_rco_nxt;
            r_valid <= 1'b1;
        end else begin
            r_rco   <= 1'b0;
            r_valid <= 1'b0;
        end
    end

    assign Q     = r_q;
    assign RCO   = r_rco;
    assign valid = r_valid;

endmodule
